// File: rtl/fpu_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : fpu_pkg                                                         |
// | Brief    : Shared defaults and op-code enum for the FPU issue scheduler.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package fpu_pkg;

    localparam int c_NUM_UNITS = 5;
    localparam int c_WIDTH     = 32;
    localparam int c_TAG_W     = 6;
    localparam int c_OP_W      = 3;
    localparam int c_DEPTH     = 4;

    // Op code doubles as the index of the unit that executes it
    typedef enum logic [c_OP_W-1:0] {
        FADD  = c_OP_W'(0),
        FSUB  = c_OP_W'(1),
        FMUL  = c_OP_W'(2),
        FDIV  = c_OP_W'(3),
        FSQRT = c_OP_W'(4)
    } fpu_op_e;

endpackage

`default_nettype wire

// File: rtl/fpu_sched_fifo.sv
// +----------------------------------------------------------------------------+
// | Module   : fpu_sched_fifo                                                  |
// | Brief    : Synchronous FIFO with show-ahead head and occupancy count.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module fpu_sched_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     i_push,
    input  logic [DW-1:0]            i_din,
    input  logic                     i_pop,
    output logic [DW-1:0]            o_dout,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage carries no reset; validity is tracked by the count alone
    always_ff @(posedge CLK) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fpu_sched.sv
// +----------------------------------------------------------------------------+
// | Module   : fpu_sched                                                       |
// | Brief    : Credit-based issue/return scheduler for a bank of FPU units.    |
// |            Optional counters enabled by defining FPU_SCHED_STATS_EN.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module fpu_sched
    import fpu_pkg::*;
#(
    parameter int NUM_UNITS = c_NUM_UNITS,
    parameter int WIDTH     = c_WIDTH,
    parameter int TAG_W     = c_TAG_W,
    parameter int DEPTH     = c_DEPTH,
    parameter int OP_W      = c_OP_W
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_W-1:0]            in_op,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [TAG_W-1:0]           in_tag,
    output logic [NUM_UNITS-1:0]       unit_valid,
    output logic [WIDTH-1:0]           unit_a,
    output logic [WIDTH-1:0]           unit_b,
    input  logic [NUM_UNITS-1:0]       unit_res_valid,
    input  logic [NUM_UNITS*WIDTH-1:0] unit_res_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic [OP_W-1:0]            out_unit,
    output logic                       busy,
    output logic                       err
`ifdef FPU_SCHED_STATS_EN
    ,
    output logic [31:0]                stat_issued,
    output logic [31:0]                stat_stall
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]     w_tag_cnt  [NUM_UNITS];
    logic [CNT_W-1:0]     w_res_cnt  [NUM_UNITS];
    logic [TAG_W-1:0]     w_tag_dout [NUM_UNITS];
    logic [WIDTH-1:0]     w_res_dout [NUM_UNITS];
    logic [NUM_UNITS-1:0] w_tag_push;
    logic [NUM_UNITS-1:0] w_res_push;
    logic [NUM_UNITS-1:0] w_spurious;
    logic [NUM_UNITS-1:0] w_res_ne;
    logic [NUM_UNITS-1:0] w_outstanding;
    logic [NUM_UNITS-1:0] w_pop;

    logic             w_in_ready;
    logic             w_legal;
    logic             w_accept;
    logic             w_issue;
    logic             w_load_ok;
    logic             w_found;
    logic             w_load;
    logic [OP_W-1:0]  w_sel;
    logic [OP_W-1:0]  w_next_ptr;
    logic [WIDTH-1:0] w_sel_data;
    logic [TAG_W-1:0] w_sel_tag;

    logic [NUM_UNITS-1:0] r_unit_valid;
    logic [WIDTH-1:0]     r_unit_a;
    logic [WIDTH-1:0]     r_unit_b;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic [TAG_W-1:0]     r_out_tag;
    logic [OP_W-1:0]      r_out_unit;
    logic                 r_err;
    logic [OP_W-1:0]      r_rr_ptr;

    assign w_legal  = int'(in_op) < NUM_UNITS;
    assign w_accept = in_valid && w_in_ready;
    assign w_issue  = w_accept && w_legal;

    // Illegal ops never match a unit, so they are always accepted and dropped
    always_comb begin
        w_in_ready = 1'b1;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (in_op == OP_W'(k) && w_tag_cnt[k] >= CNT_W'(DEPTH)) begin
                w_in_ready = 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unit
        assign w_tag_push[k]    = w_issue && (in_op == OP_W'(k));
        assign w_res_push[k]    = unit_res_valid[k] && (w_res_cnt[k] < w_tag_cnt[k]);
        assign w_spurious[k]    = unit_res_valid[k] && !(w_res_cnt[k] < w_tag_cnt[k]);
        assign w_res_ne[k]      = w_res_cnt[k] != '0;
        assign w_outstanding[k] = w_tag_cnt[k] != '0;

        fpu_sched_fifo #(
            .DW    (TAG_W),
            .DEPTH (DEPTH)
        ) u_tag_fifo (
            .CLK     (CLK),
            .RESET   (RESET),
            .i_push  (w_tag_push[k]),
            .i_din   (in_tag),
            .i_pop   (w_pop[k]),
            .o_dout  (w_tag_dout[k]),
            .o_count (w_tag_cnt[k])
        );

        fpu_sched_fifo #(
            .DW    (WIDTH),
            .DEPTH (DEPTH)
        ) u_res_fifo (
            .CLK     (CLK),
            .RESET   (RESET),
            .i_push  (w_res_push[k]),
            .i_din   (unit_res_data[k*WIDTH +: WIDTH]),
            .i_pop   (w_pop[k]),
            .o_dout  (w_res_dout[k]),
            .o_count (w_res_cnt[k])
        );
    end

    // Round-robin: first pass scans units at/after the pointer, second wraps
    always_comb begin
        w_load_ok  = !r_out_valid || out_ready;
        w_found    = 1'b0;
        w_sel      = '0;
        w_sel_data = '0;
        w_sel_tag  = '0;
        w_pop      = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (!w_found && w_res_ne[k] && ((pass == 0) == (k >= int'(r_rr_ptr)))) begin
                    w_found    = 1'b1;
                    w_sel      = OP_W'(k);
                    w_sel_data = w_res_dout[k];
                    w_sel_tag  = w_tag_dout[k];
                    w_pop[k]   = w_load_ok;
                end
            end
        end
        w_load     = w_load_ok && w_found;
        w_next_ptr = (w_sel == OP_W'(NUM_UNITS - 1)) ? '0 : w_sel + OP_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_unit_valid <= '0;
            r_unit_a     <= '0;
            r_unit_b     <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_tag    <= '0;
            r_out_unit   <= '0;
            r_err        <= 1'b0;
            r_rr_ptr     <= '0;
        end else begin
            r_unit_valid <= w_tag_push;
            r_err        <= (w_accept && !w_legal) || (|w_spurious);
            if (w_issue) begin
                r_unit_a <= in_a;
                r_unit_b <= in_b;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_tag   <= w_sel_tag;
                r_out_unit  <= w_sel;
                r_rr_ptr    <= w_next_ptr;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef FPU_SCHED_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_stall;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_issue) begin
                r_stat_issued <= r_stat_issued + 32'd1;
            end
            if (in_valid && !w_in_ready) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_stall  = r_stat_stall;
`endif

    assign in_ready   = w_in_ready;
    assign unit_valid = r_unit_valid;
    assign unit_a     = r_unit_a;
    assign unit_b     = r_unit_b;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_tag    = r_out_tag;
    assign out_unit   = r_out_unit;
    assign err        = r_err;
    assign busy       = r_out_valid || (|w_outstanding);

endmodule

`default_nettype wire
